fp8_square: RTL

- Squares one E4M3 fp8 operand per transaction: 1 sign, 4 exponent, 3 mantissa bits, bias 7.
- Performs the inverse of the fp8 square-root unit and feeds the normalisation and activation datapath.
- Multi-cycle: the significand product is formed by a 4-step shift-add loop.
- valid/ready handshakes on both sides.

---
 rtl/fp8_square.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fp8_square.sv
// fp8_square: E4M3 squarer, 4-step shift-add significand multiply, valid/ready on both sides. Rev 1.0
// Optional status output flags_o {nan, overflow, underflow} enabled by FP8_SQUARE_STATUS_EN.
`default_nettype none

module fp8_square #(
  parameter int MUL_STEPS = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] operand_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] result_o
`ifdef FP8_SQUARE_STATUS_EN
  ,
  output logic [2:0] flags_o
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_RND  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        r_cnt;
  logic [3:0]        r_sig;
  logic signed [4:0] r_exp;
  logic              r_zero;
  logic              r_nan;
  logic [7:0]        r_prod;
  logic [7:0]        r_result;

  logic [3:0]        w_dec_sig;
  logic signed [4:0] w_dec_exp;
  logic [7:0]        w_addend;
  logic [7:0]        w_q;
  logic signed [6:0] w_bexp;
  logic              w_sub;
  logic [3:0]        w_shift;
  logic [19:0]       w_x;
  logic              w_guard;
  logic              w_sticky;
  logic [4:0]        w_rnd;
  logic signed [6:0] w_bexp_n;
  logic [2:0]        w_mant;
  logic              w_ovf;
  logic [7:0]        w_pack;
  logic              w_unused_sign;

  // The square is never negative, so the operand sign only matters for NaN.
  assign w_unused_sign = operand_i[7];

  assign in_ready_o  = (r_state == S_IDLE);
  assign out_valid_o = (r_state == S_DONE);
  assign result_o    = r_result;

  always_comb begin
    w_dec_sig = {1'b1, operand_i[2:0]};
    w_dec_exp = $signed({1'b0, operand_i[6:3]}) - 5'sd7;
    if (operand_i[6:3] == 4'd0) begin
      // Subnormal: normalise so the hidden bit is set, e = -6 - shift.
      if (operand_i[2]) begin
        w_dec_sig = {operand_i[2:0], 1'b0};
        w_dec_exp = -5'sd7;
      end else if (operand_i[1]) begin
        w_dec_sig = {operand_i[1:0], 2'b00};
        w_dec_exp = -5'sd8;
      end else begin
        w_dec_sig = 4'b1000;
        w_dec_exp = -5'sd9;
      end
    end
  end

  assign w_addend = r_sig[r_cnt] ? ({4'd0, r_sig} << r_cnt) : 8'd0;

  assign w_q      = r_prod[7] ? r_prod : {r_prod[6:0], 1'b0};
  assign w_bexp   = $signed({r_exp[4], r_exp, 1'b0}) + $signed({6'd0, r_prod[7]}) + 7'sd7;
  assign w_sub    = (w_bexp <= 7'sd0);
  assign w_shift  = w_sub ? 4'(7'sd1 - w_bexp) : 4'd0;
  assign w_x      = {w_q, 12'd0} >> w_shift;
  assign w_guard  = w_x[15];
  assign w_sticky = |w_x[14:0];
  assign w_rnd    = {1'b0, w_x[19:16]} + {4'd0, w_guard & (w_sticky | w_x[16])};
  // A rounding carry (16) leaves the low bits zero and bumps the exponent.
  assign w_bexp_n = w_bexp + $signed({6'd0, w_rnd[4]});
  assign w_mant   = w_rnd[2:0];
  assign w_ovf    = !w_sub && ((w_bexp_n > 7'sd15) || ((w_bexp_n == 7'sd15) && (w_mant == 3'd7)));

  always_comb begin
    w_pack = {1'b0, w_bexp_n[3:0], w_mant};
    if (r_nan)       w_pack = 8'h7F;
    else if (r_zero) w_pack = 8'h00;
    else if (w_ovf)  w_pack = 8'h7E;
    else if (w_sub)  w_pack = {3'd0, w_rnd};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= 2'd0;
      r_sig    <= 4'd0;
      r_exp    <= 5'sd0;
      r_zero   <= 1'b0;
      r_nan    <= 1'b0;
      r_prod   <= 8'd0;
      r_result <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid_i) begin
            r_sig   <= w_dec_sig;
            r_exp   <= w_dec_exp;
            r_zero  <= (operand_i[6:0] == 7'h00);
            r_nan   <= (operand_i[6:0] == 7'h7F);
            r_prod  <= 8'd0;
            r_cnt   <= 2'd0;
            r_state <= S_MUL;
          end
        end
        S_MUL: begin
          r_prod <= r_prod + w_addend;
          r_cnt  <= r_cnt + 2'd1;
          if (r_cnt == 2'(MUL_STEPS - 1)) r_state <= S_RND;
        end
        S_RND: begin
          r_result <= w_pack;
          r_state  <= S_DONE;
        end
        S_DONE: begin
          if (out_ready_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FP8_SQUARE_STATUS_EN
  logic [2:0] r_flags;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_flags <= 3'b000;
    end else if (r_state == S_RND) begin
      r_flags <= {r_nan,
                  !r_nan && !r_zero && w_ovf,
                  !r_nan && !r_zero && (w_pack == 8'h00)};
    end
  end

  assign flags_o = r_flags;
`endif

endmodule

`default_nettype wire
